note_tone_generator: RTL and testbench
======================================

Name: note_tone_generator

Overview:
Consumes the divided sample clock from the clock divider and produces a 1-bit square-wave audio output for one note at a time. The upstream note sequencer supplies each note over a valid/ready handshake: a semitone code plus a duration in sample ticks. The block plays the note for exactly that many ticks, then signals completion. It sits between the clock divider and the speaker/PWM output pin.

Parameters:
TICK_HZ, 44130, sample tick rate in Hz (Clock 100 MHz / 2266). Documentation and table generation only.
DUR_W, 16, width of NoteDuration and of the duration counter.

Ports:
Clock  in  1  system clock, 100 MHz
Reset  in  1  asynchronous, active-high reset
SampleClk  in  1  divided clock level from the clock divider, synchronous to Clock
NoteValid  in  1  upstream has a note to play
NoteReady  out  1  block can accept a note
NoteCode  in  6  0 = rest; 1..48 = C3..B6; 49..63 = rest
NoteDuration  in  DUR_W  note length in sample ticks
Stop  in  1  abort the current note
AudioOut  out  1  square-wave output
Busy  out  1  playing a note or a rest
NoteDone  out  1  one-cycle pulse when a note completes normally

Behaviour:
- Reset is asynchronous and active-high on Clock. Reset values: AudioOut=0, NoteDone=0, Busy=0, NoteReady=1, state=IDLE, all counters=0, SampleClkQ=0.
- Tick: SampleClkQ registers SampleClk every cycle. tick = SampleClk & ~SampleClkQ, i.e. one Clock cycle per SampleClk rising edge.
- States:
  - IDLE: NoteReady=1, Busy=0.
  - PLAY: NoteReady=0, Busy=1.
- Accept: NoteValid & NoteReady on a cycle. On that cycle, latch NoteCode, NoteDuration and the half period H from the ROM.
  - Duration 0: stay IDLE. NoteDone pulses on the next cycle.
  - Otherwise: go to PLAY next cycle with DurCnt=NoteDuration, HalfCnt=H, AudioOut=0.
- A tick coinciding with the accept cycle is ignored. The first counted tick is the first one seen in PLAY.
- PLAY, on each tick:
  - DurCnt decrements.
  - HalfCnt decrements. When HalfCnt==1 before the decrement, reload H and toggle AudioOut.
  - For a rest (H=0), HalfCnt is not used and AudioOut stays 0.
- Note end: the tick where DurCnt==1 before the decrement.
  - Next cycle: state=IDLE, AudioOut=0, NoteDone=1 for exactly one cycle.
  - A new note can be accepted from the cycle after that.
- Result: a note occupies exactly D ticks. AudioOut toggles after ticks H, 2H, 3H, and so on.
- Stop in PLAY: next cycle go to IDLE, AudioOut=0, no NoteDone pulse.
  - Stop together with the final tick: Stop wins, no NoteDone.
  - Stop in IDLE: no effect.
- NoteValid/NoteCode/NoteDuration are don't-care while NoteReady=0. Upstream must hold them stable while NoteValid=1 and NoteReady=0.
- Reset mid-note: immediate return to reset values. No NoteDone.
- Width rules: H is 8 bits, range 11..169. DurCnt is DUR_W bits and never wraps, because the 0 case is handled at accept.

Decomposition:
- Shared package piano_pkg holds:
  - note code constants (NOTE_REST=0, NOTE_C3=1, NOTE_A4=22, NOTE_B6=48);
  - the state enum {IDLE, PLAY};
  - the TICK_HZ constant.
- Sub-module note_period_rom (combinational, 6-bit code -> 8-bit H):
  - H(n) = round(TICK_HZ / (2 * 440 * 2^((n-22)/12))) for n in 1..48, else 0.
  - Anchor values: C3=169, A4=50, B6=11.

Test Plan:
- Reset mid-play: start A4, assert Reset after 30 ticks -> AudioOut=0, NoteReady=1, Busy=0 immediately. No NoteDone.
- A4 tone: NoteCode=22, NoteDuration=200, bench ticks every 4 clocks -> AudioOut toggles after ticks 50, 100, 150 (high, low, high). NoteDone pulses once, the cycle after tick 200. AudioOut returns to 0.
- Rest and zero-duration: code 0 with D=10 -> Busy for 10 ticks, AudioOut stays 0, then NoteDone. Code 22 with D=0 -> NoteDone one cycle after accept, Busy never 1.
- Back-to-back with the handshake: hold NoteValid with C3 then B6 -> the second note is accepted only after NoteDone. Half periods measured as 169 then 11 ticks.
- Stop collisions: assert Stop on the same cycle as the final tick of a D=5 note -> IDLE, no NoteDone. A tick on the accept cycle is not counted: 5 counted ticks are still needed.
- Code 55 (out of range) with D=3 -> treated as a rest: AudioOut=0, NoteDone after 3 ticks.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared constants and types for the note player: note codes, widths and FSM states.
package piano_pkg;

    localparam int unsigned TICK_HZ = 44130;
    localparam int unsigned CODE_W  = 6;
    localparam int unsigned HALF_W  = 8;

    localparam logic [CODE_W-1:0] NOTE_REST = 6'd0;
    localparam logic [CODE_W-1:0] NOTE_C3   = 6'd1;
    localparam logic [CODE_W-1:0] NOTE_A4   = 6'd22;
    localparam logic [CODE_W-1:0] NOTE_B6   = 6'd48;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage : piano_pkg

// File: rtl/note_tone_generator_if.sv
// Note request handshake from the sequencer (master) to the tone generator (slave).
interface note_tone_generator_if
    import piano_pkg::*;
#(
    parameter int unsigned DUR_W = 16
) ();

    logic              NoteValid;
    logic              NoteReady;
    logic [CODE_W-1:0] NoteCode;
    logic [DUR_W-1:0]  NoteDuration;

    modport master (
        output NoteValid,
        output NoteCode,
        output NoteDuration,
        input  NoteReady
    );

    modport slave (
        input  NoteValid,
        input  NoteCode,
        input  NoteDuration,
        output NoteReady
    );

endinterface : note_tone_generator_if

// File: rtl/note_period_rom.sv
// Semitone code to square-wave half period in sample ticks; codes outside C3..B6 are rests (0).
module note_period_rom
    import piano_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [HALF_W-1:0] half_c
);

    // round(TICK_HZ / (2 * 440 * 2^((n-22)/12)))
    always_comb begin
        half_c = '0;
        case (code_i)
            NOTE_REST: half_c = 8'd0;
            NOTE_C3:   half_c = 8'd169;
            6'd2:      half_c = 8'd159;
            6'd3:      half_c = 8'd150;
            6'd4:      half_c = 8'd142;
            6'd5:      half_c = 8'd134;
            6'd6:      half_c = 8'd126;
            6'd7:      half_c = 8'd119;
            6'd8:      half_c = 8'd113;
            6'd9:      half_c = 8'd106;
            6'd10:     half_c = 8'd100;
            6'd11:     half_c = 8'd95;
            6'd12:     half_c = 8'd89;
            6'd13:     half_c = 8'd84;
            6'd14:     half_c = 8'd80;
            6'd15:     half_c = 8'd75;
            6'd16:     half_c = 8'd71;
            6'd17:     half_c = 8'd67;
            6'd18:     half_c = 8'd63;
            6'd19:     half_c = 8'd60;
            6'd20:     half_c = 8'd56;
            6'd21:     half_c = 8'd53;
            NOTE_A4:   half_c = 8'd50;
            6'd23:     half_c = 8'd47;
            6'd24:     half_c = 8'd45;
            6'd25:     half_c = 8'd42;
            6'd26:     half_c = 8'd40;
            6'd27:     half_c = 8'd38;
            6'd28:     half_c = 8'd35;
            6'd29:     half_c = 8'd33;
            6'd30:     half_c = 8'd32;
            6'd31:     half_c = 8'd30;
            6'd32:     half_c = 8'd28;
            6'd33:     half_c = 8'd27;
            6'd34:     half_c = 8'd25;
            6'd35:     half_c = 8'd24;
            6'd36:     half_c = 8'd22;
            6'd37:     half_c = 8'd21;
            6'd38:     half_c = 8'd20;
            6'd39:     half_c = 8'd19;
            6'd40:     half_c = 8'd18;
            6'd41:     half_c = 8'd17;
            6'd42:     half_c = 8'd16;
            6'd43:     half_c = 8'd15;
            6'd44:     half_c = 8'd14;
            6'd45:     half_c = 8'd13;
            6'd46:     half_c = 8'd13;
            6'd47:     half_c = 8'd12;
            NOTE_B6:   half_c = 8'd11;
            default:   half_c = 8'd0;
        endcase
    end

endmodule : note_period_rom

// File: rtl/note_tone_generator.sv
// Plays one note at a time as a 1-bit square wave, timed in sample ticks derived from SampleClk.
module note_tone_generator
    import piano_pkg::*;
#(
    parameter int unsigned DUR_W = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  SampleClk,
    note_tone_generator_if.slave  note,
    input  logic                  Stop,
    output logic                  AudioOut,
    output logic                  Busy,
    output logic                  NoteDone
);

    state_t             state_q, state_d;
    logic               sample_clk_q;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
    logic [HALF_W-1:0]  half_q, half_d;
    logic               audio_q, audio_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;

    logic               tick_c;
    logic               accept_c;
    logic [HALF_W-1:0]  rom_half_c;

    note_period_rom u_rom (
        .code_i (note.NoteCode),
        .half_c (rom_half_c)
    );

    assign tick_c   = SampleClk & ~sample_clk_q;
    assign accept_c = note.NoteValid & ready_q;

    // State and datapath registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            sample_clk_q <= 1'b0;
            dur_cnt_q    <= '0;
            half_cnt_q   <= '0;
            half_q       <= '0;
            audio_q      <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_clk_q <= SampleClk;
            dur_cnt_q    <= dur_cnt_d;
            half_cnt_q   <= half_cnt_d;
            half_q       <= half_d;
            audio_q      <= audio_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state: accept, tick counting, note end and abort
    always_comb begin
        state_d    = state_q;
        dur_cnt_d  = dur_cnt_q;
        half_cnt_d = half_cnt_q;
        half_d     = half_q;
        audio_d    = audio_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    half_d = rom_half_c;
                    if (note.NoteDuration == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = PLAY;
                        dur_cnt_d  = note.NoteDuration;
                        half_cnt_d = rom_half_c;
                        audio_d    = 1'b0;
                    end
                end
            end
            PLAY: begin
                if (Stop) begin
                    state_d = IDLE;
                    audio_d = 1'b0;
                end else if (tick_c) begin
                    if (dur_cnt_q == DUR_W'(1)) begin
                        state_d   = IDLE;
                        dur_cnt_d = '0;
                        audio_d   = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        dur_cnt_d = dur_cnt_q - DUR_W'(1);
                        // A zero half period marks a rest: the output never toggles
                        if (half_q != '0) begin
                            if (half_cnt_q == HALF_W'(1)) begin
                                half_cnt_d = half_q;
                                audio_d    = ~audio_q;
                            end else begin
                                half_cnt_d = half_cnt_q - HALF_W'(1);
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
                audio_d = 1'b0;
            end
        endcase

        // Ready is held off during the NoteDone cycle so the next note starts after it
        ready_d = (state_d == IDLE) & ~done_d;
        busy_d  = (state_d == PLAY);
    end

    assign note.NoteReady = ready_q;
    assign AudioOut       = audio_q;
    assign Busy           = busy_q;
    assign NoteDone       = done_q;

endmodule : note_tone_generator

// File: tb/tb_note_tone_generator.sv
// Scoreboard bench: stimulus queues expected output events (tick-stamped), a monitor pops and compares.
module tb_note_tone_generator;

    localparam int unsigned DUR_W = 16;
    localparam int K_AUD  = 0;
    localparam int K_BUSY = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int kind;
        int rel;
        int val;
    } ev_t;

    logic Clock     = 1'b0;
    logic Reset     = 1'b1;
    logic SampleClk = 1'b0;
    logic Stop      = 1'b0;
    logic AudioOut;
    logic Busy;
    logic NoteDone;

    note_tone_generator_if #(.DUR_W(DUR_W)) nif ();

    note_tone_generator #(.DUR_W(DUR_W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .SampleClk (SampleClk),
        .note      (nif),
        .Stop      (Stop),
        .AudioOut  (AudioOut),
        .Busy      (Busy),
        .NoteDone  (NoteDone)
    );

    always #5 Clock = ~Clock;

    int   n_cmp = 0;
    int   n_err = 0;
    ev_t  exp_q[$];
    int   consumed = 0;
    int   base = 0;
    int   done_cnt = 0;
    int   div_cnt = 0;
    bit   acc_pending = 1'b0;
    bit   sc_prev = 1'b0;
    bit   prev_audio = 1'b0;
    bit   prev_busy = 1'b0;
    bit   auto_tick = 1'b0;
    bit   man_sc = 1'b0;

    // Sample clock source: free-running 4-clock period, or driven by hand
    always @(posedge Clock) begin
        #2;
        if (auto_tick) begin
            div_cnt   = (div_cnt + 1) % 4;
            SampleClk = (div_cnt < 2);
        end else begin
            SampleClk = man_sc;
        end
    end

    // Tick bookkeeping at the edge where the DUT consumes ticks and accepts notes
    always @(posedge Clock) begin
        if (Reset) begin
            sc_prev = 1'b0;
        end else begin
            if (SampleClk && !sc_prev) consumed++;
            sc_prev = SampleClk;
            if (acc_pending) base = consumed;
        end
    end

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        int  rel;
        rel = consumed - base;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL event: got kind=%0d tick=%0d val=%0d, required no event", kind, rel, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.rel != rel || e.val != val) begin
                n_err++;
                $display("FAIL event: got kind=%0d tick=%0d val=%0d, required kind=%0d tick=%0d val=%0d",
                         kind, rel, val, e.kind, e.rel, e.val);
            end
        end
    endtask

    // Monitor: every output change or NoteDone pulse is matched against the scoreboard
    always @(negedge Clock) begin
        if (Reset) begin
            acc_pending = 1'b0;
        end else begin
            acc_pending = nif.NoteValid && nif.NoteReady;
            if (AudioOut != prev_audio) check_ev(K_AUD, int'(AudioOut));
            if (Busy != prev_busy) check_ev(K_BUSY, int'(Busy));
            if (NoteDone) begin
                check_ev(K_DONE, 1);
                done_cnt++;
            end
        end
        prev_audio = AudioOut;
        prev_busy  = Busy;
    end

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic expect_ev(input int kind, input int rel, input int val);
        ev_t e;
        e.kind = kind;
        e.rel  = rel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic wait_accept(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (nif.NoteReady) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_in_time", int'(got), 1);
        @(posedge Clock);
    endtask

    task automatic send_note(input int code, input int dur);
        @(posedge Clock);
        #1;
        nif.NoteValid    = 1'b1;
        nif.NoteCode     = 6'(code);
        nif.NoteDuration = DUR_W'(dur);
        wait_accept(100);
        #1;
        nif.NoteValid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge Clock);
            if (exp_q.size() == 0) break;
        end
        repeat (8) @(negedge Clock);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic manual_tick();
        @(posedge Clock);
        #1 man_sc = 1'b1;
        @(posedge Clock);
        #1 man_sc = 1'b0;
    endtask

    initial begin
        int d0;
        bit reached;
        nif.NoteValid    = 1'b0;
        nif.NoteCode     = '0;
        nif.NoteDuration = '0;

        repeat (3) @(posedge Clock);
        #1;
        check("rst_audio", int'(AudioOut), 0);
        check("rst_done", int'(NoteDone), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_ready", int'(nif.NoteReady), 1);
        @(negedge Clock);
        Reset     = 1'b0;
        auto_tick = 1'b1;

        // Reset in the middle of an A4 note
        expect_ev(K_BUSY, 0, 1);
        send_note(22, 200);
        reached = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock);
            if (consumed - base >= 30) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_tick30", int'(reached), 1);
        check("play_busy", int'(Busy), 1);
        check("play_ready", int'(nif.NoteReady), 0);
        @(posedge Clock);
        #1 Reset = 1'b1;
        #1;
        check("midrst_audio", int'(AudioOut), 0);
        check("midrst_ready", int'(nif.NoteReady), 1);
        check("midrst_busy", int'(Busy), 0);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (20) @(posedge Clock);
        drain(10);

        // A4 tone, 200 ticks
        expect_ev(K_BUSY, 0, 1);
        expect_ev(K_AUD, 50, 1);
        expect_ev(K_AUD, 100, 0);
        expect_ev(K_AUD, 150, 1);
        expect_ev(K_AUD, 200, 0);
        expect_ev(K_BUSY, 200, 0);
        expect_ev(K_DONE, 200, 1);
        send_note(22, 200);
        drain(1200);

        // Rest, 10 ticks
        expect_ev(K_BUSY, 0, 1);
        expect_ev(K_BUSY, 10, 0);
        expect_ev(K_DONE, 10, 1);
        send_note(0, 10);
        drain(200);

        // Zero duration: immediate completion, never busy
        expect_ev(K_DONE, 0, 1);
        send_note(22, 0);
        drain(20);

        // Out-of-range code behaves as a rest
        expect_ev(K_BUSY, 0, 1);
        expect_ev(K_BUSY, 3, 0);
        expect_ev(K_DONE, 3, 1);
        send_note(55, 3);
        drain(100);

        // Back-to-back C3 then B6 with NoteValid held
        expect_ev(K_BUSY, 0, 1);
        expect_ev(K_AUD, 169, 1);
        expect_ev(K_AUD, 338, 0);
        expect_ev(K_BUSY, 400, 0);
        expect_ev(K_DONE, 400, 1);
        expect_ev(K_BUSY, 0, 1);
        expect_ev(K_AUD, 11, 1);
        expect_ev(K_AUD, 22, 0);
        expect_ev(K_BUSY, 30, 0);
        expect_ev(K_DONE, 30, 1);
        @(posedge Clock);
        #1;
        nif.NoteValid    = 1'b1;
        nif.NoteCode     = 6'd1;
        nif.NoteDuration = DUR_W'(400);
        wait_accept(100);
        #1;
        nif.NoteCode     = 6'd48;
        nif.NoteDuration = DUR_W'(30);
        d0 = done_cnt;
        wait_accept(2500);
        #1 nif.NoteValid = 1'b0;
        check("b2b_done_before_accept", done_cnt - d0, 1);
        drain(300);

        // Hand-driven ticks from here on
        auto_tick = 1'b0;
        man_sc    = 1'b0;
        repeat (4) @(posedge Clock);

        // Stop while idle has no effect
        @(posedge Clock);
        #1 Stop = 1'b1;
        @(posedge Clock);
        #1 Stop = 1'b0;
        @(negedge Clock);
        check("idle_stop_ready", int'(nif.NoteReady), 1);
        check("idle_stop_busy", int'(Busy), 0);

        // D=5 with a tick on the accept cycle; Stop lands on the 5th counted tick
        expect_ev(K_BUSY, 0, 1);
        expect_ev(K_BUSY, 5, 0);
        d0 = done_cnt;
        @(posedge Clock);
        #1;
        nif.NoteValid    = 1'b1;
        nif.NoteCode     = 6'd22;
        nif.NoteDuration = DUR_W'(5);
        man_sc           = 1'b1;
        @(negedge Clock);
        check("stop_acc_ready", int'(nif.NoteReady), 1);
        @(posedge Clock);
        #1;
        nif.NoteValid = 1'b0;
        man_sc        = 1'b0;
        repeat (4) manual_tick();
        @(posedge Clock);
        #1;
        man_sc = 1'b1;
        Stop   = 1'b1;
        @(posedge Clock);
        #1;
        man_sc = 1'b0;
        Stop   = 1'b0;
        repeat (10) @(posedge Clock);
        drain(20);
        check("stop_no_done", done_cnt - d0, 0);

        // Same note without Stop: accept-cycle tick ignored, done after 5 counted ticks
        expect_ev(K_BUSY, 0, 1);
        expect_ev(K_BUSY, 5, 0);
        expect_ev(K_DONE, 5, 1);
        @(posedge Clock);
        #1;
        nif.NoteValid    = 1'b1;
        nif.NoteCode     = 6'd22;
        nif.NoteDuration = DUR_W'(5);
        man_sc           = 1'b1;
        @(posedge Clock);
        #1;
        nif.NoteValid = 1'b0;
        man_sc        = 1'b0;
        repeat (5) manual_tick();
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_note_tone_generator
